// File: rtl/path_meter_pkg.sv
// Shared definitions for the path delay meter: FSM state encodings and the
// saturation value reported on a timed-out measurement.
package path_meter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRESETTLE = 3'd1,
      ST_LAUNCH    = 3'd2,
      ST_WAIT      = 3'd3,
      ST_DONE      = 3'd4
   } meterState_e;

   // Wide enough for any counter width in use; callers slice what they need.
   localparam logic [63:0] SAT = '1;

endpackage

// File: rtl/path_sync.sv
// Multi-flop synchroniser for the asynchronous delay-path output.
// Clears to 0 on the synchronous reset.
module path_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic asyncIn,
   output logic syncOut
);

   (* ASYNC_REG = "TRUE", keep = "true" *) logic [STAGES-1:0] syncFf;

   always_ff @(posedge clk) begin
      if (rst) begin
         syncFf <= '0;
      end else begin
         syncFf <= {syncFf[STAGES-2:0], asyncIn};
      end
   end

   assign syncOut = syncFf[STAGES-1];

endmodule

// File: rtl/path_delay_meter.sv
// Launch-and-capture controller for one chained delay path: toggles the path
// input, counts cycles until the synchronised output follows, averages samples.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  IDLE      | waiting for start
//  PRESETTLE | waiting for the path output to match the current drive level
//  LAUNCH    | one cycle: toggle path_input, restart the sample counter
//  WAIT      | counting until the launched edge arrives (or timeout)
//  DONE      | one cycle: done pulse, results valid
import path_meter_pkg::*;

module path_delay_meter #(
   parameter int CNT_W       = 16,
   parameter int AVG_LOG2    = 2,
   parameter int TIMEOUT     = 1000,
   parameter int SYNC_STAGES = 2,
   parameter bit PATH_INV    = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             path_input,
   input  logic             path_result,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] delay_cycles,
   output logic             timeout
);

   localparam int ACC_W = CNT_W + AVG_LOG2;
   localparam int IDX_W = AVG_LOG2 + 1;
   localparam logic [IDX_W-1:0] NUM_SAMPLES  = IDX_W'(2 ** AVG_LOG2);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SAT_CNT      = SAT[CNT_W-1:0];

   meterState_e      state, stateNext;
   logic [CNT_W-1:0] cnt, cntNext;
   logic [IDX_W-1:0] idx, idxNext, idxInc;
   logic [ACC_W-1:0] acc, accNext, accSum;
   logic             pathInputReg, pathInputNext;
   logic [CNT_W-1:0] delayReg, delayNext;
   logic             timeoutReg, timeoutNext;
   logic             sres;
   logic             expLevel;
   logic             match;

   path_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .asyncIn (path_result),
      .syncOut (sres)
   );

   assign expLevel = pathInputReg ^ PATH_INV;
   assign match    = (sres == expLevel);
   assign accSum   = acc + ACC_W'(cnt);
   assign idxInc   = idx + 1'b1;

   always_comb begin
      stateNext     = state;
      cntNext       = cnt;
      idxNext       = idx;
      accNext       = acc;
      pathInputNext = pathInputReg;
      delayNext     = delayReg;
      timeoutNext   = timeoutReg;
      case (state)
         ST_IDLE: begin
            if (start) begin
               stateNext   = ST_PRESETTLE;
               cntNext     = '0;
               idxNext     = '0;
               accNext     = '0;
               timeoutNext = 1'b0;
            end
         end
         ST_PRESETTLE: begin
            if (match) begin
               stateNext = ST_LAUNCH;
            end else begin
               cntNext = cnt + 1'b1;
               if (cnt >= TIMEOUT_LAST) begin
                  stateNext   = ST_DONE;
                  timeoutNext = 1'b1;
                  delayNext   = SAT_CNT;
               end
            end
         end
         ST_LAUNCH: begin
            pathInputNext = ~pathInputReg;
            cntNext       = CNT_W'(1);
            stateNext     = ST_WAIT;
         end
         ST_WAIT: begin
            if (match) begin
               accNext = accSum;
               idxNext = idxInc;
               if (idxInc == NUM_SAMPLES) begin
                  stateNext = ST_DONE;
                  delayNext = CNT_W'(accSum >> AVG_LOG2);
               end else begin
                  stateNext = ST_LAUNCH;
               end
            end else begin
               // Timeout lands exactly TIMEOUT cycles after the LAUNCH cycle.
               cntNext = cnt + 1'b1;
               if (cnt >= TIMEOUT_LAST) begin
                  stateNext   = ST_DONE;
                  timeoutNext = 1'b1;
                  delayNext   = SAT_CNT;
               end
            end
         end
         ST_DONE: begin
            stateNext = ST_IDLE;
         end
         default: begin
            stateNext = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         idx          <= '0;
         acc          <= '0;
         pathInputReg <= 1'b0;
         delayReg     <= '0;
         timeoutReg   <= 1'b0;
      end else begin
         state        <= stateNext;
         cnt          <= cntNext;
         idx          <= idxNext;
         acc          <= accNext;
         pathInputReg <= pathInputNext;
         delayReg     <= delayNext;
         timeoutReg   <= timeoutNext;
      end
   end

   assign path_input   = pathInputReg;
   assign busy         = (state == ST_PRESETTLE) || (state == ST_LAUNCH) || (state == ST_WAIT);
   assign done         = (state == ST_DONE);
   assign delay_cycles = delayReg;
   assign timeout      = timeoutReg;

endmodule

// File: tb/tb_path_delay_meter.sv
// Directed bench: two meters (1 sample / inverting path, 4 samples / plain path)
// each driven through a delay-line model of its chained path.
module tb_path_delay_meter;

   localparam int TMO = 40;
   localparam logic [1:0] INV = 2'b01;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  start;
   logic [1:0]  pathInput;
   logic [1:0]  pathResult;
   logic [1:0]  busy;
   logic [1:0]  done;
   logic [15:0] delayCycles [2];
   logic [1:0]  timeout;

   always #5 clk = ~clk;

   path_delay_meter #(
      .CNT_W(16), .AVG_LOG2(0), .TIMEOUT(TMO), .SYNC_STAGES(2), .PATH_INV(1'b1)
   ) dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .path_input(pathInput[0]),
      .path_result(pathResult[0]), .busy(busy[0]), .done(done[0]),
      .delay_cycles(delayCycles[0]), .timeout(timeout[0])
   );

   path_delay_meter #(
      .CNT_W(16), .AVG_LOG2(2), .TIMEOUT(TMO), .SYNC_STAGES(2), .PATH_INV(1'b0)
   ) dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .path_input(pathInput[1]),
      .path_result(pathResult[1]), .busy(busy[1]), .done(done[1]),
      .delay_cycles(delayCycles[1]), .timeout(timeout[1])
   );

   // Path model: mode 0 = delay line of dCur cycles, 1 = stuck 0, 2 = stuck 1.
   logic [15:0] hist [2] = '{16'h0, 16'h0};
   int dCur [2] = '{0, 0};
   int mode [2] = '{0, 0};
   int dSeq [2][4];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) hist[i] <= {hist[i][14:0], pathInput[i]};
   end

   always_comb begin
      pathResult = '0;
      for (int i = 0; i < 2; i++) begin
         if (mode[i] == 1)      pathResult[i] = 1'b0;
         else if (mode[i] == 2) pathResult[i] = 1'b1;
         else if (dCur[i] == 0) pathResult[i] = pathInput[i] ^ INV[i];
         else                   pathResult[i] = hist[i][dCur[i]-1] ^ INV[i];
      end
   end

   typedef struct {
      int          sel;
      int          mode;
      int          d0, d1, d2, d3;
      logic [15:0] expDelay;
      logic        expTo;
      int          expToggles;
      logic        expPi;
      int          expGap;
   } vec_t;

   vec_t vecs [10];

   int passCnt = 0;
   int checkCnt = 0;
   int cyc = 0;
   int doneCyc = 0;
   int toggles [2] = '{0, 0};
   int lastToggle [2] = '{0, 0};
   logic [1:0] prevPi = 2'b00;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checkCnt++;
      if (got === exp) passCnt++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // One clock; tracks path_input edges and switches the model delay per sample.
   task automatic stepCycle();
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (pathInput[i] !== prevPi[i]) begin
            toggles[i]++;
            lastToggle[i] = cyc;
            if (mode[i] == 0 && toggles[i] >= 1 && toggles[i] <= 4) dCur[i] = dSeq[i][toggles[i]-1];
         end
      end
      prevPi = pathInput;
   endtask

   task automatic measure(input int sel, input int extraAt, output bit gotDone, output bit busy1);
      toggles[sel] = 0;
      gotDone = 1'b0;
      busy1 = 1'b0;
      for (int k = 0; k < 400 && !gotDone; k++) begin
         start[sel] = (k == 0) || (k == extraAt);
         stepCycle();
         start[sel] = 1'b0;
         if (k == 0) busy1 = busy[sel];
         if (done[sel] === 1'b1) begin
            gotDone = 1'b1;
            doneCyc = cyc;
         end
      end
   endtask

   task automatic setModel(input int sel, input int m, input int a, input int b, input int c, input int d);
      mode[sel] = m;
      dSeq[sel][0] = a; dSeq[sel][1] = b; dSeq[sel][2] = c; dSeq[sel][3] = d;
      dCur[sel] = a;
   endtask

   initial begin
      bit gotDone, busy1, anyBusy, anyDone;

      //         sel mode d0 d1 d2 d3  delay     to  tog pi  gap
      vecs[0] = '{0, 0, 0, 0, 0, 0, 16'd3,     0,  1,  1,  3};
      vecs[1] = '{1, 0, 5, 5, 5, 5, 16'd8,     0,  4,  0,  8};
      vecs[2] = '{1, 0, 4, 5, 5, 6, 16'd8,     0,  4,  0,  9};
      vecs[3] = '{1, 0, 4, 4, 4, 5, 16'd7,     0,  4,  0,  8};
      vecs[4] = '{1, 0, 1, 2, 3, 4, 16'd5,     0,  4,  0,  7};
      vecs[5] = '{0, 0, 2, 2, 2, 2, 16'd5,     0,  1,  0,  5};
      vecs[6] = '{0, 0, 7, 7, 7, 7, 16'd10,    0,  1,  1, 10};
      vecs[7] = '{1, 2, 0, 0, 0, 0, 16'hFFFF,  1,  0,  0, -1};
      vecs[8] = '{1, 1, 0, 0, 0, 0, 16'hFFFF,  1,  1,  1, TMO-1};
      vecs[9] = '{0, 1, 0, 0, 0, 0, 16'hFFFF,  1,  1,  0, TMO-1};

      start = 2'b00;
      rst = 1'b1;
      repeat (3) stepCycle();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("reset_pi%0d", i), 32'(pathInput[i]), 0);
         check($sformatf("reset_busy%0d", i), 32'(busy[i]), 0);
         check($sformatf("reset_done%0d", i), 32'(done[i]), 0);
         check($sformatf("reset_delay%0d", i), 32'(delayCycles[i]), 0);
         check($sformatf("reset_timeout%0d", i), 32'(timeout[i]), 0);
      end
      rst = 1'b0;
      repeat (2) stepCycle();

      for (int v = 0; v < 10; v++) begin
         int s;
         s = vecs[v].sel;
         setModel(s, vecs[v].mode, vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].d3);
         repeat (12) stepCycle();
         measure(s, -1, gotDone, busy1);
         check($sformatf("v%0d_done", v), 32'(gotDone), 1);
         check($sformatf("v%0d_busy_after_start", v), 32'(busy1), 1);
         check($sformatf("v%0d_busy_at_done", v), 32'(busy[s]), 0);
         check($sformatf("v%0d_delay", v), 32'(delayCycles[s]), 32'(vecs[v].expDelay));
         check($sformatf("v%0d_timeout", v), 32'(timeout[s]), 32'(vecs[v].expTo));
         check($sformatf("v%0d_toggles", v), 32'(toggles[s]), 32'(vecs[v].expToggles));
         check($sformatf("v%0d_path_input", v), 32'(pathInput[s]), 32'(vecs[v].expPi));
         if (vecs[v].expGap >= 0)
            check($sformatf("v%0d_edge_to_done", v), 32'(doneCyc - lastToggle[1-1+s]), 32'(vecs[v].expGap));
      end

      // Reset in the middle of a WAIT on the 4-sample meter.
      setModel(1, 0, 20, 20, 20, 20);
      repeat (12) stepCycle();
      toggles[1] = 0;
      start[1] = 1'b1;
      stepCycle();
      start[1] = 1'b0;
      for (int k = 0; k < 100 && toggles[1] == 0; k++) stepCycle();
      repeat (3) stepCycle();
      check("midwait_busy", 32'(busy[1]), 1);
      rst = 1'b1;
      stepCycle();
      check("midrst_pi", 32'(pathInput[1]), 0);
      check("midrst_busy", 32'(busy[1]), 0);
      check("midrst_done", 32'(done[1]), 0);
      check("midrst_delay", 32'(delayCycles[1]), 0);
      check("midrst_timeout", 32'(timeout[1]), 0);
      check("midrst_delay_other", 32'(delayCycles[0]), 0);
      rst = 1'b0;

      // Fresh run with a stray start while busy: (4 * (3+3)) >> 2 = 6.
      setModel(1, 0, 3, 3, 3, 3);
      repeat (12) stepCycle();
      measure(1, 3, gotDone, busy1);
      check("fresh_done", 32'(gotDone), 1);
      check("fresh_delay", 32'(delayCycles[1]), 6);
      check("fresh_timeout", 32'(timeout[1]), 0);

      // Start presented during DONE must be dropped.
      start[1] = 1'b1;
      stepCycle();
      start[1] = 1'b0;
      anyBusy = 1'b0;
      anyDone = 1'b0;
      repeat (40) begin
         stepCycle();
         anyBusy |= busy[1];
         anyDone |= done[1];
      end
      check("done_start_busy", 32'(anyBusy), 0);
      check("done_start_done", 32'(anyDone), 0);

      // Start in the cycle right after done is accepted.
      measure(1, -1, gotDone, busy1);
      check("back2back_first_done", 32'(gotDone), 1);
      stepCycle();
      measure(1, -1, gotDone, busy1);
      check("back2back_busy", 32'(busy1), 1);
      check("back2back_done", 32'(gotDone), 1);
      check("back2back_delay", 32'(delayCycles[1]), 6);

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
